// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-way round-robin arbiter with a bounded hold time.
// Requester index k maps to request/grant bit (3-k): index 00 is bit 3.
// The grant code selects the shared datapath source; the one-hot grant
// drives the per-requester enables.
module rr_arbiter_4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);
  localparam logic             HOLD_EN = (HOLD_MAX != 0);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;   // first index searched on the next new grant
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0]   req_ix;         // requests re-ordered so bit k is index k
  logic [N_REQ-1:0]   holder_mask;
  logic [N_REQ-1:0]   other_req;
  logic               holder_req;
  logic [IDX_W:0]     pick_all;
  logic [IDX_W:0]     pick_oth;
  logic               hold_limit;
  logic               cnt_sat;
  logic               issue;
  logic [IDX_W-1:0]   issue_idx;

  // First set bit of mask searched from start upward (mod 4); MSB = found.
  function automatic logic [IDX_W:0] rr_pick(input logic [IDX_W-1:0] start,
                                            input logic [N_REQ-1:0] mask);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] k;
    res = '0;
    for (int o = N_REQ - 1; o >= 0; o--) begin
      k = start + IDX_W'(o);
      if (mask[k]) begin
        res = {1'b1, k};
      end
    end
    return res;
  endfunction

  // Index code to one-hot grant bit (index 00 -> 4'b1000).
  function automatic logic [N_REQ-1:0] idx_to_gnt(input logic [IDX_W-1:0] k);
    return N_REQ'(4'b1000 >> k);
  endfunction

  // Index-ordered view of the request vector and holder-relative terms.
  always_comb begin
    req_ix      = {req[0], req[1], req[2], req[3]};
    holder_mask = '0;
    holder_mask[idx_q] = 1'b1;
    other_req   = req_ix & ~holder_mask;
    holder_req  = req_ix[idx_q];
    pick_all    = rr_pick(ptr_q, req_ix);
    pick_oth    = rr_pick(ptr_q, other_req);
    hold_limit  = HOLD_EN && (cnt_q == CNT_MAX);
    cnt_sat     = !HOLD_EN || (cnt_q == CNT_MAX);
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    issue_idx = idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_all[IDX_W]) begin
          issue     = 1'b1;
          issue_idx = pick_all[IDX_W-1:0];
        end
      end
      ST_GRANT: begin
        if (!holder_req) begin
          if (pick_oth[IDX_W]) begin
            // holder released with others waiting: hand over without a bubble
            issue     = 1'b1;
            issue_idx = pick_oth[IDX_W-1:0];
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end else if (hold_limit && pick_oth[IDX_W]) begin
          // holder used its full slot: forced rotation
          issue     = 1'b1;
          issue_idx = pick_oth[IDX_W-1:0];
        end else if (!cnt_sat) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase

    if (issue) begin
      state_d = ST_GRANT;
      gnt_d   = idx_to_gnt(issue_idx);
      idx_d   = issue_idx;
      valid_d = 1'b1;
      ptr_d   = issue_idx + IDX_W'(1);
      cnt_d   = CNT_ONE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

`ifndef SYNTHESIS
  // Grant is never more than one-hot and the valid flag tracks it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(gnt_q));
      assert (valid_q == (|gnt_q));
    end
  end
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: vector table, directed corner sequences and random
// traffic checked against an index-level reference model, for three
// HOLD_MAX settings side by side.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;

  logic [3:0] gnt_a   [3];
  logic [1:0] idx_a   [3];
  logic       valid_a [3];

  always #5 clk = ~clk;

  rr_arbiter_4 #(.HOLD_MAX(8)) u_hm8 (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt_a[0]), .gnt_idx(idx_a[0]), .gnt_valid(valid_a[0]));
  rr_arbiter_4 #(.HOLD_MAX(0)) u_hm0 (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt_a[1]), .gnt_idx(idx_a[1]), .gnt_valid(valid_a[1]));
  rr_arbiter_4 #(.HOLD_MAX(4)) u_hm4 (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt_a[2]), .gnt_idx(idx_a[2]), .gnt_valid(valid_a[2]));

  int n_cmp = 0;
  int n_bad = 0;
  int hm_tab [3] = '{8, 0, 4};

  // reference model state, one set per instance
  int m_on [3];
  int m_h  [3];
  int m_last [3];
  int m_cnt [3];
  int m_idx [3];

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [1:0] ix;
    logic       v;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requesting index after 'after' in circular order, skipping excl.
  function automatic int pick(input int after, input logic [3:0] r, input int excl);
    for (int o = 1; o <= 4; o++) begin
      int k;
      k = (after + o) % 4;
      if (r[3-k] && k != excl) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_on[i] = 0; m_h[i] = 0; m_last[i] = 3; m_cnt[i] = 0; m_idx[i] = 0;
    end
  endtask

  task automatic m_grant(input int i, input int k);
    m_on[i] = 1; m_h[i] = k; m_last[i] = k; m_idx[i] = k; m_cnt[i] = 1;
  endtask

  task automatic model_step(input logic [3:0] r);
    for (int i = 0; i < 3; i++) begin
      int hm, h, oth, k;
      bit own;
      hm = hm_tab[i];
      if (m_on[i] == 0) begin
        k = pick(m_last[i], r, -1);
        if (k >= 0) m_grant(i, k);
      end else begin
        h   = m_h[i];
        own = r[3-h];
        oth = pick(h, r, h);
        if (!own && oth >= 0)                         m_grant(i, oth);
        else if (!own) begin m_on[i] = 0; m_cnt[i] = 0; end
        else if (hm != 0 && m_cnt[i] == hm && oth >= 0) m_grant(i, oth);
        else if (hm != 0 && m_cnt[i] < hm)            m_cnt[i]++;
      end
    end
  endtask

  task automatic check_models();
    for (int i = 0; i < 3; i++) begin
      logic [3:0] e;
      e = (m_on[i] != 0) ? (4'b1000 >> m_h[i]) : 4'b0000;
      chk($sformatf("model_hm%0d {gnt,idx,valid}", hm_tab[i]),
          32'({gnt_a[i], idx_a[i], valid_a[i]}),
          32'({e, 2'(m_idx[i]), (m_on[i] != 0)}));
    end
  endtask

  // One clock: drive at negedge, model the edge, compare just after it.
  task automatic cycle(input logic [3:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    if (!reset) model_step(r);
    #1;
    check_models();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b0000;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  int wait_c [4];
  int max_wait;
  logic [3:0] r, prev;

  initial begin
    tbl[0]  = '{4'b1111, 4'b1000, 2'd0, 1'b1};
    tbl[1]  = '{4'b1111, 4'b1000, 2'd0, 1'b1};
    tbl[2]  = '{4'b0111, 4'b0100, 2'd1, 1'b1};
    tbl[3]  = '{4'b0111, 4'b0100, 2'd1, 1'b1};
    tbl[4]  = '{4'b0011, 4'b0010, 2'd2, 1'b1};
    tbl[5]  = '{4'b0011, 4'b0010, 2'd2, 1'b1};
    tbl[6]  = '{4'b1001, 4'b0001, 2'd3, 1'b1};
    tbl[7]  = '{4'b1001, 4'b0001, 2'd3, 1'b1};
    tbl[8]  = '{4'b1000, 4'b1000, 2'd0, 1'b1};
    tbl[9]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[10] = '{4'b0001, 4'b0001, 2'd3, 1'b1};
    tbl[11] = '{4'b0000, 4'b0000, 2'd3, 1'b0};
    tbl[12] = '{4'b1010, 4'b1000, 2'd0, 1'b1};
    tbl[13] = '{4'b0010, 4'b0010, 2'd2, 1'b1};
    tbl[14] = '{4'b0000, 4'b0000, 2'd2, 1'b0};

    reset = 1'b1;
    req   = 4'b0000;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_hm%0d {gnt,idx,valid}", hm_tab[i]),
          32'({gnt_a[i], idx_a[i], valid_a[i]}), 32'(0));
    end
    reset = 1'b0;

    // reset arriving mid-grant clears outputs without waiting for an edge
    cycle(4'b1111);
    chk("pre_reset gnt", 32'(gnt_a[0]), 32'(4'b1000));
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async_reset_hm%0d {gnt,valid}", hm_tab[i]),
          32'({gnt_a[i], valid_a[i]}), 32'(0));
    end
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b0000;
    cycle(4'b0010);
    chk("post_reset gnt", 32'(gnt_a[0]), 32'(4'b0010));
    chk("post_reset idx", 32'(idx_a[0]), 32'(2'd2));

    // lone requester keeps the grant well past HOLD_MAX
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cycle(4'b0100);
      chk($sformatf("single c%0d {gnt,idx}", c), 32'({gnt_a[0], idx_a[0]}),
          32'({4'b0100, 2'd1}));
    end
    cycle(4'b0000);
    chk("single drop gnt", 32'({gnt_a[0], valid_a[0]}), 32'(0));

    // rotation order, no-bubble handover, index wrap and pointer
    do_reset();
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].r);
      chk($sformatf("vec%0d {gnt,idx,valid}", i),
          32'({gnt_a[0], idx_a[0], valid_a[0]}),
          32'({tbl[i].g, tbl[i].ix, tbl[i].v}));
    end

    // forced rotation with HOLD_MAX=8, none with HOLD_MAX=0
    do_reset();
    for (int c = 1; c <= 24; c++) begin
      cycle(4'b1001);
      chk($sformatf("force_hm8 c%0d", c), 32'(gnt_a[0]),
          32'((c <= 8 || c >= 17) ? 4'b1000 : 4'b0001));
      chk($sformatf("force_hm0 c%0d", c), 32'(gnt_a[1]), 32'(4'b1000));
    end

    // random traffic against the model, starvation bound for HOLD_MAX=4
    do_reset();
    max_wait = 0;
    prev = 4'b0000;
    for (int k = 0; k < 4; k++) wait_c[k] = 0;
    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 3))
        0:       r = 4'($urandom);
        1:       r = prev | 4'($urandom);
        default: r = prev;
      endcase
      if (n % 64 == 0) r = 4'($urandom);
      prev = r;
      cycle(r);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rand_hm%0d onehot0", hm_tab[i]), 32'($onehot0(gnt_a[i])), 32'(1));
        chk($sformatf("rand_hm%0d valid", hm_tab[i]), 32'(valid_a[i]), 32'(|gnt_a[i]));
      end
      for (int k = 0; k < 4; k++) begin
        if (r[3-k] && !gnt_a[2][3-k]) wait_c[k]++;
        else wait_c[k] = 0;
        if (wait_c[k] > max_wait) max_wait = wait_c[k];
      end
    end
    chk("starvation max_wait<=15", 32'(max_wait <= 15), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
